times5_stream_kernel: RTL and testbench

- Self-contained streaming kernel with an HLS-style block-level handshake (start/idle/ready/done).
- On each start it generates an internal frame of N_PIXELS input samples, multiplies each by 5 and streams the products out.
- It also accumulates a 32-bit checksum of all products.
- Serves as the top-level smoke-test kernel for the times-5 hardware pipeline; only the control ports are needed to run it.

---
 rtl/times5_stream_kernel.sv | 211 +++++++++++++++++++++
 tb/tb_times5_stream_kernel.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/times5_stream_kernel.sv
// times5_stream_kernel: block-level handshake kernel that generates a frame
// of N_PIXELS samples (0,1,2,... mod 2^IN_W), streams out sample*5 one per
// cycle and accumulates a 32-bit checksum of the products.

module times5_stream_kernel_chk (
    input logic clk,
    input logic rst,
    input logic ap_idle,
    input logic ap_ready,
    input logic ap_done,
    input logic hw_output_vld,
    input logic hw_output_last
);

    // Ready for the last sample is always followed by done.
    a_ready_then_done : assert property (@(posedge clk) disable iff (rst)
        ap_ready |=> ap_done);

    // Done coincides with the final, valid product.
    a_done_has_last : assert property (@(posedge clk) disable iff (rst)
        ap_done |-> (hw_output_vld && hw_output_last));

    // Last is only ever flagged on a valid product.
    a_last_implies_vld : assert property (@(posedge clk) disable iff (rst)
        hw_output_last |-> hw_output_vld);

    // Nothing streams while idle.
    a_idle_quiet : assert property (@(posedge clk) disable iff (rst)
        ap_idle |-> !hw_output_vld);

    // Idle and done are mutually exclusive state decodes.
    a_idle_done_excl : assert property (@(posedge clk) disable iff (rst)
        !(ap_idle && ap_done));

endmodule

module times5_stream_kernel #(
    parameter int N_PIXELS = 64,
    parameter int IN_W     = 8,
    parameter int OUT_W    = 16
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             ap_start,
    output logic             ap_idle,
    output logic             ap_ready,
    output logic             ap_done,
    output logic [OUT_W-1:0] hw_output_value,
    output logic             hw_output_vld,
    output logic             hw_output_last,
    output logic [31:0]      checksum
);

    // idx counts 0..N_PIXELS, so it needs room for N_PIXELS itself.
    localparam int IDX_W = $clog2(N_PIXELS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIXELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [IDX_W-1:0]   idx_r;
    logic [IN_W-1:0]    sample_s;
    logic [OUT_W-1:0]   product_s;
    logic               is_last_s;
    logic [OUT_W-1:0]   value_r;
    logic               vld_r;
    logic               last_r;
    logic [31:0]        checksum_r;

    // Multiply by five as a shift-and-add; the zero-extension to OUT_W
    // happens before the shift so no product bits are lost.
    function automatic logic [OUT_W-1:0] times5(input logic [IN_W-1:0] x);
        logic [OUT_W-1:0] xe;
        xe = OUT_W'(x);
        return (xe << 2) + xe;
    endfunction

    // Input sample is idx modulo 2^IN_W: truncate or zero-extend idx.
    generate
        if (IDX_W >= IN_W) begin : g_sample_trunc
            assign sample_s = idx_r[IN_W-1:0];
        end else begin : g_sample_ext
            assign sample_s = {{(IN_W - IDX_W){1'b0}}, idx_r};
        end
    endgenerate

    assign product_s = times5(sample_s);
    assign is_last_s = (idx_r == LAST_IDX);

    // State register.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: IDLE waits for start, RUN issues N_PIXELS samples,
    // DONE lasts exactly one cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ap_start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (is_last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Handshake flags decoded directly from state and idx.
    always_comb begin
        ap_idle  = 1'b0;
        ap_ready = 1'b0;
        ap_done  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ap_idle = 1'b1;
            end
            ST_RUN: begin
                if (is_last_s) begin
                    ap_ready = 1'b1;
                end else begin
                    ap_ready = 1'b0;
                end
            end
            ST_DONE: begin
                ap_done = 1'b1;
            end
            default: begin
                ap_idle = 1'b0;
            end
        endcase
    end

    // Sample counter, product register and checksum accumulator.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            idx_r      <= {IDX_W{1'b0}};
            value_r    <= {OUT_W{1'b0}};
            vld_r      <= 1'b0;
            last_r     <= 1'b0;
            checksum_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    vld_r  <= 1'b0;
                    last_r <= 1'b0;
                    if (ap_start) begin
                        idx_r      <= {IDX_W{1'b0}};
                        checksum_r <= 32'd0;
                    end
                end
                ST_RUN: begin
                    value_r    <= product_s;
                    vld_r      <= 1'b1;
                    last_r     <= is_last_s;
                    checksum_r <= checksum_r + 32'(product_s);
                    idx_r      <= idx_r + {{(IDX_W - 1){1'b0}}, 1'b1};
                end
                ST_DONE: begin
                    // The final product was visible during DONE; drop the
                    // valid/last flags as we return to IDLE, keep the data.
                    vld_r  <= 1'b0;
                    last_r <= 1'b0;
                end
                default: begin
                    vld_r  <= 1'b0;
                    last_r <= 1'b0;
                end
            endcase
        end
    end

    assign hw_output_value = value_r;
    assign hw_output_vld   = vld_r;
    assign hw_output_last  = last_r;
    assign checksum        = checksum_r;

    times5_stream_kernel_chk u_chk (
        .clk            (ap_clk),
        .rst            (ap_rst),
        .ap_idle        (ap_idle),
        .ap_ready       (ap_ready),
        .ap_done        (ap_done),
        .hw_output_vld  (vld_r),
        .hw_output_last (last_r)
    );

endmodule

// File: tb/tb_times5_stream_kernel.sv
// Scoreboard bench for times5_stream_kernel: a default 64-sample instance
// and a 300-sample instance that exercises the 8-bit input wrap.

module tb_times5_stream_kernel;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start_w;

    logic        idle, ready, done, vld, last;
    logic [15:0] value;
    logic [31:0] csum;

    logic        idle_w, ready_w, done_w, vld_w, last_w;
    logic [15:0] value_w;
    logic [31:0] csum_w;

    typedef struct {
        logic [15:0] val;
        logic        last;
        logic [31:0] sum;
    } exp_t;

    exp_t q[$];
    exp_t qw[$];

    int n_vec = 0;
    int n_mis = 0;
    int widx  = 0;

    always #5 clk = ~clk;

    times5_stream_kernel dut (
        .ap_clk          (clk),
        .ap_rst          (rst),
        .ap_start        (start),
        .ap_idle         (idle),
        .ap_ready        (ready),
        .ap_done         (done),
        .hw_output_value (value),
        .hw_output_vld   (vld),
        .hw_output_last  (last),
        .checksum        (csum)
    );

    times5_stream_kernel #(.N_PIXELS(300), .IN_W(8), .OUT_W(16)) dut_w (
        .ap_clk          (clk),
        .ap_rst          (rst),
        .ap_start        (start_w),
        .ap_idle         (idle_w),
        .ap_ready        (ready_w),
        .ap_done         (done_w),
        .hw_output_value (value_w),
        .hw_output_vld   (vld_w),
        .hw_output_last  (last_w),
        .checksum        (csum_w)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model of one frame: sample i -> (i mod 256)*5, checksum restarts at 0.
    task automatic push_frame(input int n, input bit to_w);
        exp_t        e;
        logic [31:0] s;
        s = 32'd0;
        for (int i = 0; i < n; i++) begin
            e.val  = 16'((i % 256) * 5);
            s      = s + 32'(e.val);
            e.sum  = s;
            e.last = (i == n - 1);
            if (to_w) qw.push_back(e);
            else      q.push_back(e);
        end
    endtask

    task automatic wait_done(input int bound, output int cyc);
        cyc = 0;
        while (!done && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    // Scoreboard for the default instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && vld) begin
            if (q.size() == 0) begin
                chk("unexpected_vld", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("value", 32'(value), 32'(e.val));
                chk("last", 32'(last), 32'(e.last));
                chk("done_with_last", 32'(done), 32'(e.last));
                chk("checksum", csum, e.sum);
            end
        end
    end

    // Scoreboard for the wrapping instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && vld_w) begin
            if (qw.size() == 0) begin
                chk("wrap_unexpected_vld", 32'd1, 32'd0);
            end else begin
                e = qw.pop_front();
                chk("wrap_value", 32'(value_w), 32'(e.val));
                chk("wrap_last", 32'(last_w), 32'(e.last));
                chk("wrap_checksum", csum_w, e.sum);
                if (widx == 256) chk("wrap_sample256", 32'(value_w), 32'd0);
                if (widx == 299) chk("wrap_sample299", 32'(value_w), 32'd215);
                widx++;
            end
        end
    end

    initial begin
        int cyc;
        int act;
        int dn;

        rst     = 1'b1;
        start   = 1'b0;
        start_w = 1'b0;
        @(negedge clk);
        chk("in_reset_vld", 32'(vld), 32'd0);
        chk("in_reset_idle", 32'(idle), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_vld", 32'(vld), 32'd0);
        chk("rst_last", 32'(last), 32'd0);
        chk("rst_value", 32'(value), 32'd0);
        chk("rst_checksum", csum, 32'd0);
        chk("rst_idle_w", 32'(idle_w), 32'd1);

        // Default frame started by a single-cycle pulse.
        push_frame(64, 1'b0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("idle_after_start", 32'(idle), 32'd0);
        @(negedge clk);
        for (int c = 0; c <= 65; c++) begin
            chk("ready_timing", 32'(ready), 32'(c == 63));
            chk("done_timing", 32'(done), 32'(c == 64));
            chk("idle_timing", 32'(idle), 32'(c >= 65));
            if (c == 64) chk("checksum_at_done", csum, 32'd10080);
            @(negedge clk);
        end
        chk("frame_drained", 32'(q.size()), 32'd0);

        act = 0;
        repeat (500) begin
            if (done || ready || vld || last || !idle) act++;
            @(negedge clk);
        end
        chk("quiet_after_frame", 32'(act), 32'd0);
        chk("checksum_hold", csum, 32'd10080);
        chk("value_hold", 32'(value), 32'd315);

        // Reset in the middle of a frame.
        push_frame(64, 1'b0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_vld", 32'(vld), 32'd0);
        chk("midrst_last", 32'(last), 32'd0);
        chk("midrst_value", 32'(value), 32'd0);
        chk("midrst_checksum", csum, 32'd0);
        chk("midrst_idle", 32'(idle), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (100) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("no_done_after_rst", 32'(dn), 32'd0);

        // Back-to-back frames with start held high.
        push_frame(64, 1'b0);
        push_frame(64, 1'b0);
        start = 1'b1;
        wait_done(200, cyc);
        chk("b2b_csum1", csum, 32'd10080);
        @(negedge clk);
        chk("b2b_idle_gap", 32'(idle), 32'd1);
        @(negedge clk);
        chk("b2b_restart", 32'(idle), 32'd0);
        wait_done(200, cyc);
        chk("b2b_frame_len", 32'(cyc), 32'd64);
        chk("b2b_csum2", csum, 32'd10080);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_drained", 32'(q.size()), 32'd0);
        chk("b2b_idle_end", 32'(idle), 32'd1);

        // 300-sample frame on the wrapping instance.
        push_frame(300, 1'b1);
        start_w = 1'b1;
        @(posedge clk);
        #1 start_w = 1'b0;
        cyc = 0;
        while (!done_w && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("wrap_done_seen", 32'(done_w), 32'd1);
        chk("wrap_checksum_final", csum_w, 32'd167930);
        repeat (3) @(negedge clk);
        chk("wrap_drained", 32'(qw.size()), 32'd0);
        chk("wrap_idle_end", 32'(idle_w), 32'd1);
        chk("wrap_ready_low", 32'(ready_w), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
